// File: rtl/commit_halt_monitor_if.sv
// ============================================================================
//  Module      : commit_halt_monitor_if
//  Description : ROB commit bus plus drain-status flags seen by the
//                commit_halt_monitor. The master drives the commit slots and
//                the empty flags; the slave (monitor) only observes them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_halt_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COMMIT = 2
);
    logic [NUM_COMMIT-1:0]            commit_valid;
    logic [NUM_COMMIT*ADDR_WIDTH-1:0] commit_pc;
    logic [NUM_COMMIT*DATA_WIDTH-1:0] commit_instr;
    logic                             rob_empty;
    logic                             sb_empty;

    modport master (
        output commit_valid,
        output commit_pc,
        output commit_instr,
        output rob_empty,
        output sb_empty
    );

    modport slave (
        input commit_valid,
        input commit_pc,
        input commit_instr,
        input rob_empty,
        input sb_empty
    );
endinterface

`default_nettype wire

// File: rtl/commit_halt_monitor.sv
// ============================================================================
//  Module      : commit_halt_monitor
//  Description : End-of-program detector. Finds the oldest committed halt
//                instruction, optionally waits for the ROB and store buffer
//                to drain, then raises a sticky done. Keeps cycle/instret
//                counters, records the halt PC and forces done on timeout.
//  Config      : HALT_DRAIN_EN defined   -> RUN -> DRAIN -> DONE
//                HALT_DRAIN_EN undefined -> RUN -> DONE (drain flags ignored)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_halt_monitor #(
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH = 32,
    parameter int                     NUM_COMMIT = 2,
    parameter int                     CNT_WIDTH  = 32,
    parameter int unsigned            MAX_CYCLES = 32'd100000,
    parameter logic [DATA_WIDTH-1:0]  HALT_INSTR = 32'h00100073
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [ADDR_WIDTH-1:0] boot_pc,
    commit_halt_monitor_if.slave       cif,
    output logic                       done,
    output logic                       timeout,
    output logic [ADDR_WIDTH-1:0]      halted_pc,
    output logic [CNT_WIDTH-1:0]       cycle_count,
    output logic [CNT_WIDTH-1:0]       instret_count
);

    localparam logic [CNT_WIDTH-1:0] C_LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

`ifdef HALT_DRAIN_EN
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DONE  = 2'd2
    } state_t;

    // Drain flags have no effect when the drain phase is compiled out.
    logic unused_drain_flags;
    assign unused_drain_flags = cif.rob_empty ^ cif.sb_empty;
`endif

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic [ADDR_WIDTH-1:0]   halted_pc_q, halted_pc_d;
    logic [CNT_WIDTH-1:0]    cycle_count_q, cycle_count_d;
    logic [CNT_WIDTH-1:0]    instret_count_q, instret_count_d;

    logic                    halt_seen;
    logic [ADDR_WIDTH-1:0]   halt_pc;
    logic [CNT_WIDTH-1:0]    retire_cnt;
    logic                    at_last_cycle;

    // Scan slots oldest-first: count retirements up to and including the
    // first halt, and capture that halt's PC. Younger slots are dropped.
    always_comb begin
        halt_seen  = 1'b0;
        halt_pc    = '0;
        retire_cnt = '0;
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (cif.commit_valid[k] && !halt_seen) begin
                retire_cnt = retire_cnt + CNT_WIDTH'(1);
                if (cif.commit_instr[k*DATA_WIDTH +: DATA_WIDTH] == HALT_INSTR) begin
                    halt_seen = 1'b1;
                    halt_pc   = cif.commit_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    assign at_last_cycle = (cycle_count_q == C_LAST_CYCLE);

    // Next-state and next-output logic; DONE freezes everything.
    always_comb begin
        state_d         = state_q;
        done_d          = done_q;
        timeout_d       = timeout_q;
        halted_pc_d     = halted_pc_q;
        cycle_count_d   = cycle_count_q;
        instret_count_d = instret_count_q;
        case (state_q)
            RUN: begin
                cycle_count_d   = cycle_count_q + CNT_WIDTH'(1);
                instret_count_d = instret_count_q + retire_cnt;
                if (halt_seen) begin
                    // A halt beats a same-cycle timeout.
                    halted_pc_d = halt_pc;
`ifdef HALT_DRAIN_EN
                    state_d     = DRAIN;
`else
                    state_d     = DONE;
                    done_d      = 1'b1;
`endif
                end else if (at_last_cycle) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
`ifdef HALT_DRAIN_EN
            DRAIN: begin
                cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
                if (at_last_cycle) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (cif.rob_empty && cif.sb_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            halted_pc_q     <= boot_pc;
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            state_q         <= state_d;
            done_q          <= done_d;
            timeout_q       <= timeout_d;
            halted_pc_q     <= halted_pc_d;
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign done          = done_q;
    assign timeout       = timeout_q;
    assign halted_pc     = halted_pc_q;
    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;

endmodule

`default_nettype wire
